// File: rtl/sub32bit_seq.sv
// Chunk-serial subtractor: {bout,d} = a - b - bin, CHUNK bits per clock, LSB chunk first.
// Latency: done is high in the cycle after the (n/CHUNK)-th edge that follows the accepting edge.
// Backpressure: start is taken only in IDLE or DONE; it is ignored while busy and is never queued.
module sub32bit_seq #(
    parameter int n     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         bin,
    output logic [n-1:0] d,
    output logic         bout,
    output logic         busy,
    output logic         done
);

    localparam int NCH = n / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [n-1:0]   a_q;
    logic [n-1:0]   b_q;
    logic [n-1:0]   acc;
    logic [n-1:0]   acc_nxt;
    logic           borrow;
    logic [IW-1:0]  idx;
    logic [CHUNK:0] diff;
    logic           last;
    logic           accept;
    int             lo;

    assign last   = (idx == IW'(NCH - 1));
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // One chunk of subtraction; the extra top bit of diff is the chunk borrow-out.
    always_comb begin
        lo      = int'(idx) * CHUNK;
        diff    = {1'b0, a_q[lo +: CHUNK]} - {1'b0, b_q[lo +: CHUNK]}
                  - {{CHUNK{1'b0}}, borrow};
        acc_nxt = acc;
        acc_nxt[lo +: CHUNK] = diff[CHUNK-1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: DONE lasts one cycle and can chain straight into RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, chunk walk, and result publish only on the final chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            d      <= '0;
            bout   <= 1'b0;
        end else if (accept) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            idx    <= '0;
            acc    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_nxt;
            borrow <= diff[CHUNK];
            idx    <= idx + 1'b1;
            if (last) begin
                d    <= acc_nxt;
                bout <= diff[CHUNK];
            end
        end
    end

endmodule

// File: tb/tb_sub32bit_seq.sv
// Self-checking bench for sub32bit_seq: directed table, multi-cycle corner sequences, random ops.
// Latency: expects done exactly 4 edges after the accepting edge with default parameters.
// Backpressure: exercises start while busy (ignored) and start held through DONE (chained).
module tb_sub32bit_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

    sub32bit_seq #(.n(32), .CHUNK(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .d     (d),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", passed, total);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] exp_d;
        logic        exp_bout;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Starting at the current negedge (index 0), wait for done; count busy cycles seen.
    task automatic wait_result(input bit scramble, output int busy_cycles, output int done_at);
        busy_cycles = 0;
        done_at     = -1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (done) begin
                done_at = i;
                if (scramble) start = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
            if (scramble) begin
                a     = $urandom;
                b     = $urandom;
                bin   = 1'($urandom_range(1));
                start = 1'($urandom_range(1));
            end
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                          input logic vbin, input logic [31:0] ed, input logic eb,
                          input bit full_checks, input bit scramble);
        int bc;
        int da;
        @(negedge clk);
        a = va; b = vb; bin = vbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result(scramble, bc, da);
        if (full_checks) begin
            chk({name, " done_latency"}, 64'(da), 64'd4);
            chk({name, " busy_cycles"}, 64'(bc), 64'd4);
            chk({name, " d"}, 64'(d), 64'(ed));
            chk({name, " bout"}, 64'(bout), 64'(eb));
            @(negedge clk);
            chk({name, " done_one_cycle"}, 64'(done), 64'd0);
        end else begin
            if (da < 0) chk({name, " timeout"}, 64'(da), 64'd4);
            else chk({name, " result"}, {31'd0, bout, d}, {31'd0, eb, ed});
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mbin);
        return {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
    endfunction

    vec_t vecs[7];

    initial begin
        int bc;
        int da;
        bit seen;
        logic [32:0] r;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rbin;

        vecs[0] = '{32'd5,         32'd3,         1'b0, 32'h0000_0002, 1'b0};
        vecs[1] = '{32'd0,         32'd1,         1'b0, 32'hFFFF_FFFF, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h0123_4566, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0};
        vecs[6] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 32'hFFFF_FFFF, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset d", 64'(d), 64'd0);
        chk("reset bout", 64'(bout), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                   vecs[i].exp_d, vecs[i].exp_bout, 1'b1, 1'b0);
        end

        // start re-pulsed with new operands two cycles into RUN is ignored.
        @(negedge clk);
        a = 32'd100; b = 32'd30; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 32'd7; b = 32'd9; bin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result(1'b0, bc, da);
        chk("ignored_start latency", 64'(da), 64'd2);
        chk("ignored_start d", 64'(d), 64'd70);
        chk("ignored_start bout", 64'(bout), 64'd0);
        @(negedge clk);
        chk("ignored_start back_to_idle", 64'(busy), 64'd0);

        // start held through DONE chains a second op with no IDLE cycle.
        @(negedge clk);
        a = 32'd1000; b = 32'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 32'd3; b = 32'd5; bin = 1'b0;
        wait_result(1'b0, bc, da);
        chk("chain first latency", 64'(da), 64'd4);
        chk("chain first d", 64'(d), 64'd999);
        @(negedge clk);
        start = 1'b0;
        chk("chain no_idle busy", 64'(busy), 64'd1);
        chk("chain no_idle done", 64'(done), 64'd0);
        wait_result(1'b0, bc, da);
        chk("chain second latency", 64'(da), 64'd4);
        chk("chain second d", 64'(d), 64'hFFFF_FFFE);
        chk("chain second bout", 64'(bout), 64'd1);

        // Reset two cycles into RUN aborts; start during reset is ignored.
        @(negedge clk);
        a = 32'd50; b = 32'd20; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort d", 64'(d), 64'd0);
        chk("abort bout", 64'(bout), 64'd0);
        start = 1'b1;
        @(negedge clk);
        chk("start_in_reset busy", 64'(busy), 64'd0);
        start = 1'b0;
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("abort no_done", 64'(seen), 64'd0);
        chk("abort d_held", 64'(d), 64'd0);
        run_op("after_abort", 32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b1, 1'b0);

        // Random operands, random gaps, random input noise while busy.
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(2)) @(negedge clk);
            ra   = $urandom;
            rb   = (k % 4 == 0) ? ra : $urandom;
            rbin = 1'($urandom_range(1));
            r    = model(ra, rb, rbin);
            run_op($sformatf("rand%0d", k), ra, rb, rbin, r[31:0], r[32], 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sub32bit_seq.md
SUB32BIT_SEQ -- requirements
Module: sub32bit_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. Ports SHALL be named clk and rst.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- n, 32, operand width.
- CHUNK, 8, bits processed per cycle; n SHALL be a multiple of CHUNK.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; operands sampled when accepted.
- a  input  n  minuend.
- b  input  n  subtrahend.
- bin  input  1  borrow-in.
- d  output  n  registered difference.
- bout  output  1  registered borrow-out.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-005 start SHALL be accepted only on a rising clk edge in IDLE or DONE. On acceptance, the block SHALL latch a, b and bin, clear the chunk index to 0, and enter RUN.
REQ-006 start SHALL be ignored in RUN. The latched operands SHALL NOT change, and there SHALL be no queuing.
REQ-007 In RUN, each edge SHALL process chunk k (bits k*CHUNK+CHUNK-1 down to k*CHUNK), with k starting at 0 (the LSB chunk). Each chunk SHALL compute a_k - b_k - borrow into an internal accumulator, and the borrow SHALL update to the chunk borrow-out.
REQ-008 The initial borrow SHALL be the latched bin.
REQ-009 After chunk n/CHUNK-1 is processed, the FSM SHALL enter DONE. On that same edge, d SHALL load the full accumulated result and bout SHALL load the final borrow.
REQ-010 Latency: done SHALL be high for exactly the cycle following the (n/CHUNK)-th edge after the accepting edge. This is 4 edges with the defaults.
REQ-011 DONE SHALL last one cycle. The FSM SHALL then go to IDLE, or to RUN if start is high on that edge (back-to-back operation).
REQ-012 busy SHALL be high exactly while in RUN.
REQ-013 d and bout SHALL hold the last completed result until the next completion. Partial chunk results SHALL never appear on d.
REQ-014 Arithmetic: the result SHALL be unsigned modulo 2^n. {bout,d} SHALL equal a - b - bin in (n+1)-bit two's complement. bout SHALL be 1 if and only if a < b + bin (unsigned, evaluated without truncation).
REQ-015 Input changes on a, b or bin while in RUN SHALL NOT affect the result.

Reset
REQ-016 Asserting rst SHALL immediately, without waiting for clk, force:
- FSM to IDLE;
- d = 0, bout = 0, busy = 0, done = 0;
- chunk index and accumulator to 0.
REQ-017 rst asserted mid-operation SHALL abort the operation. No done pulse SHALL be produced for the aborted operation, and d SHALL remain 0.
REQ-018 While rst is high, start SHALL be ignored. The first accepting edge SHALL be the first rising clk edge with rst low and start high.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- a=5, b=3, bin=0, start for one cycle -> busy for 4 cycles; done pulse 4 edges after acceptance; d=0x00000002, bout=0.
- a=0, b=1, bin=0 -> d=0xFFFFFFFF, bout=1.
- a=0xFFFFFFFF, b=0xFFFFFFFF, bin=1 -> d=0xFFFFFFFF, bout=1.
- a=0x00000100, b=0x00000001, bin=0 (borrow crosses the chunk boundary) -> d=0x000000FF, bout=0.
- start pulsed again, with new operands, 2 cycles into RUN -> ignored; the result is still from the first operands.
- start held high through DONE -> a second operation starts with no IDLE cycle.
- rst pulsed 2 cycles into RUN -> busy=0, done never pulses, d=0. A following start with a=10, b=4 -> d=6.
REQ-020 The bench SHALL compare each completion against a reference model of {bout,d} = a - b - bin. It SHALL run at least 1000 random operand sets with random start timing, and SHALL report zero mismatches.
